semafor_param: RTL
==================

SEMAFOR_PARAM -- requirements
Module: semafor_param

Interface
REQ-001 Parameter T_VERDE_MIN, default 8: minimum car-green duration, in cycles.
REQ-002 Parameter T_GALBEN, default 3: car-yellow duration, in cycles.
REQ-003 Parameter T_GARDA, default 2: all-red clearance duration, in cycles.
REQ-004 Parameter T_PIETONI, default 6: steady pedestrian-green duration, in cycles.
REQ-005 Parameter T_CLIPIRE_TOT, default 4: blinking pedestrian-green duration, in cycles.
REQ-006 Parameter T_CLIPIRE, default 2: blink half-period, in cycles; applies to pedestrian blink and night flash.
REQ-007 Parameter CNT_W, default 16: timer width; every T_* parameter SHALL be between 1 and 2^CNT_W-1.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous and active-low.
REQ-010 buton_pietoni  input  1  pedestrian request, synchronous to clk, active-high.
REQ-011 mod_noapte  input  1  night-mode request (flashing yellow), synchronous, level.
REQ-012 masini_rosu, masini_galben, masini_verde  output  1 each  car lamps.
REQ-013 pietoni_verde, pietoni_rosu  output  1 each  pedestrian lamps.
REQ-014 cerere_activa  output  1  latched pedestrian request pending.
REQ-015 stare  output  3  current state encoding, for debug.

Function
REQ-016 States and stare codes: VERDE=0, GALBEN=1, GARDA1=2, PIETONI=3, CLIPIRE=4, GARDA2=5, NOAPTE=6.
REQ-017 Lamps per state:
  - VERDE: masini_verde, pietoni_rosu.
  - GALBEN: masini_galben, pietoni_rosu.
  - GARDA1 and GARDA2: masini_rosu, pietoni_rosu.
  - PIETONI: masini_rosu, pietoni_verde.
  - CLIPIRE: masini_rosu, pietoni_verde=blink flag, pietoni_rosu=0.
  - NOAPTE: masini_galben=blink flag; all other lamps 0.
REQ-018 Outputs SHALL be decoded from registered state and registered blink flag only; no combinational input-to-output path.
REQ-019 Timer: on entry to a state, load T_x-1; decrement each cycle; the state's time has elapsed when the timer is 0. Each timed state therefore lasts exactly T_x cycles.
REQ-020 VERDE: the timer saturates at 0. Exit at the first edge where the timer is 0 and either mod_noapte=1 (go to NOAPTE) or cerere_activa=1 (go to GALBEN). mod_noapte has priority.
REQ-021 Fixed sequence on timer 0: GALBEN -> GARDA1 -> PIETONI -> CLIPIRE -> GARDA2 -> VERDE. mod_noapte is ignored in these states.
REQ-022 Button edge detection: buton_pietoni is registered once; a rising edge is buton_pietoni=1 with previous sample 0.
REQ-023 A rising edge sets cerere_activa on the next edge in states VERDE, GALBEN, GARDA1 and GARDA2. Edges in PIETONI, CLIPIRE and NOAPTE are ignored. A held button latches once only.
REQ-024 cerere_activa clears on entry to PIETONI and on entry to NOAPTE. If a set and a clear coincide, the clear wins.
REQ-025 Blink flag: set to 1 on entry to CLIPIRE or NOAPTE; toggles every T_CLIPIRE cycles while in either state; 0 in all other states.
REQ-026 NOAPTE is untimed. When mod_noapte=0, the next state is GARDA2; from there the normal flow continues to VERDE.
REQ-027 Request latency: if cerere_activa is set after the minimum green has expired, GALBEN begins one cycle later.

Reset
REQ-028 While rst_n=0:
  - stare=VERDE; masini_verde=1, pietoni_rosu=1; all other lamps 0.
  - timer=T_VERDE_MIN-1; cerere_activa=0; blink flag=0; button history=0.
REQ-029 Asserting rst_n mid-sequence, including PIETONI or NOAPTE, SHALL return the block to the REQ-028 values immediately, without waiting for a clock.

Verification
REQ-030 Defaults; release reset, pulse the button at cycle 2 -> VERDE for 8 cycles after release, then GALBEN 3, GARDA1 2, PIETONI 6, CLIPIRE 4 with pietoni_verde pattern 1,1,0,0, GARDA2 2, then VERDE.
REQ-031 No button press for 100 cycles -> the block stays in VERDE and cerere_activa stays 0.
REQ-032 Button pulse at cycle 20 (after the minimum green) -> cerere_activa=1 at cycle 21 and GALBEN at cycle 22.
REQ-033 Button pressed during PIETONI, then held high for 10 cycles starting in VERDE -> a single latch only; the press in PIETONI has no effect.
REQ-034 mod_noapte=1 together with a pending request at the end of the minimum green -> NOAPTE with masini_galben pattern 1,1,0,0,... and cerere_activa cleared. Dropping mod_noapte -> GARDA2 for 2 cycles, then VERDE.
REQ-035 rst_n pulsed low asynchronously mid-PIETONI -> outputs immediately match the REQ-028 values.

Source files
------------

// File: rtl/semafor_param.sv
// semafor_param: car/pedestrian crossing controller with night flashing mode
module semafor_param #(
  parameter int T_VERDE_MIN   = 8,
  parameter int T_GALBEN      = 3,
  parameter int T_GARDA       = 2,
  parameter int T_PIETONI     = 6,
  parameter int T_CLIPIRE_TOT = 4,
  parameter int T_CLIPIRE     = 2,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buton_pietoni,
  input  logic       mod_noapte,
  output logic       masini_rosu,
  output logic       masini_galben,
  output logic       masini_verde,
  output logic       pietoni_verde,
  output logic       pietoni_rosu,
  output logic       cerere_activa,
  output logic [2:0] stare
);
  localparam logic [2:0] VERDE   = 3'd0;
  localparam logic [2:0] GALBEN  = 3'd1;
  localparam logic [2:0] GARDA1  = 3'd2;
  localparam logic [2:0] PIETONI = 3'd3;
  localparam logic [2:0] CLIPIRE = 3'd4;
  localparam logic [2:0] GARDA2  = 3'd5;
  localparam logic [2:0] NOAPTE  = 3'd6;

  logic [2:0]       stare_q, stare_d;
  logic [CNT_W-1:0] timer_q, timer_d, blk_cnt_q, blk_cnt_d;
  logic             cerere_q, cerere_d, blink_q, blink_d, buton_q, buton_d;
  logic             tz, entry, blink_st, rise, set_ok, clr;

  function automatic logic [CNT_W-1:0] dur(input logic [2:0] s);
    return s == VERDE   ? CNT_W'(T_VERDE_MIN - 1) :
           s == GALBEN  ? CNT_W'(T_GALBEN - 1) :
           s == PIETONI ? CNT_W'(T_PIETONI - 1) :
           s == CLIPIRE ? CNT_W'(T_CLIPIRE_TOT - 1) :
           (s == GARDA1 || s == GARDA2) ? CNT_W'(T_GARDA - 1) : '0;
  endfunction

  // state, timers, request latch, blink flag and button history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stare_q   <= VERDE;
      timer_q   <= CNT_W'(T_VERDE_MIN - 1);
      blk_cnt_q <= CNT_W'(T_CLIPIRE - 1);
      cerere_q  <= 1'b0;
      blink_q   <= 1'b0;
      buton_q   <= 1'b0;
    end else begin
      stare_q   <= stare_d;
      timer_q   <= timer_d;
      blk_cnt_q <= blk_cnt_d;
      cerere_q  <= cerere_d;
      blink_q   <= blink_d;
      buton_q   <= buton_d;
    end
  end

  // next state: VERDE waits for min green plus night/request, NOAPTE waits for night to drop
  always_comb begin
    tz      = timer_q == '0;
    stare_d = stare_q;
    case (stare_q)
      VERDE:   if (tz) stare_d = mod_noapte ? NOAPTE : cerere_q ? GALBEN : VERDE;
      GALBEN:  if (tz) stare_d = GARDA1;
      GARDA1:  if (tz) stare_d = PIETONI;
      PIETONI: if (tz) stare_d = CLIPIRE;
      CLIPIRE: if (tz) stare_d = GARDA2;
      GARDA2:  if (tz) stare_d = VERDE;
      NOAPTE:  if (!mod_noapte) stare_d = GARDA2;
      default: stare_d = VERDE;
    endcase
  end

  // timers reload on state entry; request latch with clear-over-set; blink toggling
  always_comb begin
    entry     = stare_d != stare_q;
    timer_d   = entry ? dur(stare_d) : tz ? '0 : timer_q - 1'b1;
    blink_st  = stare_d == CLIPIRE || stare_d == NOAPTE;
    blink_d   = !blink_st ? 1'b0 : entry ? 1'b1 : blk_cnt_q == '0 ? ~blink_q : blink_q;
    blk_cnt_d = (!blink_st || entry || blk_cnt_q == '0) ? CNT_W'(T_CLIPIRE - 1) : blk_cnt_q - 1'b1;
    buton_d   = buton_pietoni;
    rise      = buton_pietoni & ~buton_q;
    set_ok    = stare_q == VERDE || stare_q == GALBEN || stare_q == GARDA1 || stare_q == GARDA2;
    clr       = entry && (stare_d == PIETONI || stare_d == NOAPTE);
    cerere_d  = clr ? 1'b0 : cerere_q | (rise & set_ok);
  end

  // lamps decoded from registered state and blink flag only
  always_comb begin
    masini_rosu   = stare_q == GARDA1 || stare_q == PIETONI || stare_q == CLIPIRE || stare_q == GARDA2;
    masini_galben = stare_q == GALBEN || (stare_q == NOAPTE && blink_q);
    masini_verde  = stare_q == VERDE;
    pietoni_verde = stare_q == PIETONI || (stare_q == CLIPIRE && blink_q);
    pietoni_rosu  = stare_q == VERDE || stare_q == GALBEN || stare_q == GARDA1 || stare_q == GARDA2;
    cerere_activa = cerere_q;
    stare         = stare_q;
  end
endmodule
